led_sequence_player: RTL

Output-side counterpart to the push-button debouncer in the memory game. It plays a stored sequence of LED indices on the board LEDs: each step lights one LED for a fixed on-time, then blanks all LEDs for a fixed gap. When playback finishes it signals completion, and the game FSM then switches to reading debounced player presses.

---
 rtl/game_pkg.sv | 43 ++++
 rtl/phase_timer.sv | 35 +++
 rtl/led_sequence_player.sv | 139 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared constants, state encoding and small helpers
// for the memory-game LED sequence player.
package game_pkg;

  localparam int NUM_LEDS = 4;
  localparam int MAX_LEN  = 16;
  localparam int LEN_W    = 5;
  localparam int IDX_W    = 2;
  localparam int TIMER_W  = 16;
  localparam int DATA_W   = IDX_W * MAX_LEN;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  function automatic logic [LEN_W-1:0] clamp_len(
    input logic [LEN_W-1:0] len
  );
    if (len > LEN_W'(MAX_LEN)) begin
      return LEN_W'(MAX_LEN);
    end
    return len;
  endfunction

  function automatic logic [NUM_LEDS-1:0] led_onehot(
    input logic [IDX_W-1:0] idx
  );
    logic [NUM_LEDS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [IDX_W-1:0] entry_at(
    input logic [DATA_W-1:0] data,
    input logic [LEN_W-1:0]  i
  );
    logic [LEN_W-1:0] base;
    base = {i[LEN_W-2:0], 1'b0};
    return data[base +: IDX_W];
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable 16-bit down-counter that saturates at zero
// and flags when it has reached zero.
module phase_timer
  import game_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               zero
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/led_sequence_player.sv
// Plays a latched sequence of LED indices: each step lights
// one LED for ON_CYCLES, then blanks for OFF_CYCLES.
module led_sequence_player
  import game_pkg::*;
#(
  parameter logic [TIMER_W-1:0] ON_CYCLES  = 16'd50000,
  parameter logic [TIMER_W-1:0] OFF_CYCLES = 16'd25000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [LEN_W-1:0]    seq_len,
  input  logic [DATA_W-1:0]   seq_data,
  output logic [NUM_LEDS-1:0] led,
  output logic                busy,
  output logic [LEN_W-1:0]    step,
  output logic                done
);

  logic [1:0]          state_q, state_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                busy_q, busy_d;
  logic [LEN_W-1:0]    step_q, step_d;
  logic                done_q, done_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                timer_load;
  logic [TIMER_W-1:0]  timer_val;
  logic                timer_zero;
  logic [LEN_W-1:0]    start_len;
  logic [LEN_W-1:0]    next_step;

  assign start_len = clamp_len(seq_len);
  assign next_step = step_q + LEN_W'(1);

  phase_timer u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    led_d      = led_q;
    busy_d     = busy_q;
    step_d     = step_q;
    done_d     = 1'b0;
    len_d      = len_q;
    data_d     = data_q;
    timer_load = 1'b0;
    timer_val  = '0;

    // abort outranks start and any timer expiry
    if (abort) begin
      state_d = ST_IDLE;
      led_d   = '0;
      busy_d  = 1'b0;
    end else begin
      unique case (1'b1)
        (state_q == ST_IDLE): begin
          led_d  = '0;
          busy_d = 1'b0;
          if (start) begin
            if (start_len != '0) begin
              len_d      = start_len;
              data_d     = seq_data;
              step_d     = '0;
              state_d    = ST_ON;
              busy_d     = 1'b1;
              led_d      = led_onehot(seq_data[IDX_W-1:0]);
              timer_load = 1'b1;
              timer_val  = ON_CYCLES - TIMER_W'(1);
            end else begin
              done_d = 1'b1;
            end
          end
        end
        (state_q == ST_ON): begin
          if (timer_zero) begin
            state_d    = ST_GAP;
            led_d      = '0;
            timer_load = 1'b1;
            timer_val  = OFF_CYCLES - TIMER_W'(1);
          end
        end
        (state_q == ST_GAP): begin
          if (timer_zero) begin
            if (next_step < len_q) begin
              step_d     = next_step;
              state_d    = ST_ON;
              led_d      = led_onehot(entry_at(data_q, next_step));
              timer_load = 1'b1;
              timer_val  = ON_CYCLES - TIMER_W'(1);
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          led_d   = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      led_q   <= '0;
      busy_q  <= 1'b0;
      step_q  <= '0;
      done_q  <= 1'b0;
      len_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      step_q  <= step_d;
      done_q  <= done_d;
      len_q   <= len_d;
      data_q  <= data_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign step = step_q;
  assign done = done_q;

endmodule
